// File: rtl/sync_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_ram_pkg: shared types, default sizes and byte-merge helper            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sync_ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Widest word the merge helper handles; callers extend and truncate with casts.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ram_2p_clear_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_ram_clear_ctrl: post-reset sweep that zeroes every word, then READY   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_ram_clear_ctrl
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_we    = (state_q == ST_CLEAR);
  assign clr_addr  = cnt_q;
  assign init_done = (state_q == ST_READY);

endmodule
`default_nettype wire

// File: rtl/sync_ram_2p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_ram_2p: simple dual-port sync RAM, byte enables, write-first bypass   |
// | SYNC_RAM_OUT_REG_EN adds an output register (read latency 2). Rev 1.0      |
// +----------------------------------------------------------------------------+
module sync_ram_2p
  import sync_ram_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_fire, rd_fire, rd_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, wr_merged, rd_word, rd_bypass;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  sync_ram_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  // User traffic is dropped, not queued, until the sweep finishes.
  assign wr_fire = wr_en & init_done;
  assign rd_fire = rd_en & init_done;
  assign rd_hit  = wr_fire && (wr_addr == rd_addr);
  assign rd_word = mem_q[rd_addr];

  always_comb begin
    wr_merged = DATA_W'(be_merge(MERGE_W'(mem_q[wr_addr]), MERGE_W'(wr_data),
                                 MERGE_BE_W'(wr_be)));
    mem_we    = clr_we | wr_fire;
    mem_addr  = clr_we ? clr_addr : wr_addr;
    mem_wdata = clr_we ? '0 : wr_merged;
    // On a same-address hit the stored word is the write target, so the
    // merged write data is exactly the write-first result.
    rd_bypass  = rd_hit ? wr_merged : rd_word;
    rd_data_d  = rd_fire ? rd_bypass : rd_data_q;
    rd_valid_d = rd_fire;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SYNC_RAM_OUT_REG_EN
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    out_data_d  = rd_data_q;
    out_valid_d = rd_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;
`else
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
`default_nettype wire
